// File: rtl/led_uart_reporter_if.sv
// LED reporter signal bundle: LED input from the ALU stage plus UART/status outputs.
interface led_uart_reporter_if #(
    parameter int CNT_W = 3
);
    logic [7:0]       iLed;
    logic             oTx;
    logic             oBusy;
    logic             oOverflow;
    logic [CNT_W-1:0] oFifoCount;

    modport master (
        output iLed,
        input  oTx,
        input  oBusy,
        input  oOverflow,
        input  oFifoCount
    );

    modport slave (
        input  iLed,
        output oTx,
        output oBusy,
        output oOverflow,
        output oFifoCount
    );
endinterface

// File: rtl/led_uart_reporter.sv
// Watches the LED bus, queues every changed value and sends it out as 8N1 UART frames.
module led_uart_reporter #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_W        = 3
) (
    input logic                Clock,
    input logic                Reset,
    led_uart_reporter_if.slave ledBus
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_t;

    txState_t         state;
    txState_t         stateNext;
    logic [7:0]       rLedPrev;
    logic [7:0]       fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] count;
    logic [7:0]       shiftReg;
    logic [BAUD_W-1:0] baudCnt;
    logic [2:0]       bitIdx;
    logic             rTx;
    logic             txNext;
    logic             rOverflow;
    logic             pushReq;
    logic             pushOk;
    logic             pop;
    logic             fifoFull;
    logic             baudDone;

    assign pushReq  = (ledBus.iLed != rLedPrev);
    assign fifoFull = (count == CNT_W'(FIFO_DEPTH));
    assign pop      = (state == IDLE) && (count != '0);
    // A full FIFO still accepts a push when the head leaves at the same edge.
    assign pushOk   = pushReq && (!fifoFull || pop);
    assign baudDone = (baudCnt == BAUD_W'(CLKS_PER_BIT - 1));

    // Change detector and sticky overflow flag.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            rLedPrev  <= '0;
            rOverflow <= 1'b0;
        end else begin
            rLedPrev <= ledBus.iLed;
            if (pushReq && fifoFull && !pop) begin
                rOverflow <= 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset because the pointers gate every read.
    always_ff @(posedge Clock) begin
        if (Reset && pushOk) begin
            fifoMem[wrPtr] <= ledBus.iLed;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushOk) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({pushOk, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // TX state register.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // TX next-state logic.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (count != '0) stateNext = START;
            START:   if (baudDone) stateNext = DATA;
            DATA:    if (baudDone && bitIdx == 3'd7) stateNext = STOP;
            STOP:    if (baudDone) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Baud counter, bit index and shift register.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            baudCnt  <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
        end else if (state == IDLE) begin
            baudCnt <= '0;
            bitIdx  <= '0;
            if (pop) begin
                shiftReg <= fifoMem[rdPtr];
            end
        end else begin
            baudCnt <= baudDone ? '0 : baudCnt + 1'b1;
            if (state == DATA && baudDone) begin
                bitIdx   <= bitIdx + 1'b1;
                shiftReg <= shiftReg >> 1;
            end
        end
    end

    // TX output decode: value the line takes after the coming edge.
    // Within DATA the shift happens at the same edge, so the next bit is shiftReg[1].
    always_comb begin
        txNext = 1'b1;
        case (stateNext)
            START:   txNext = 1'b0;
            DATA:    txNext = (state == DATA && baudDone) ? shiftReg[1] : shiftReg[0];
            default: txNext = 1'b1;
        endcase
    end

    // Registered TX pin, idle high.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            rTx <= 1'b1;
        end else begin
            rTx <= txNext;
        end
    end

    assign ledBus.oTx        = rTx;
    assign ledBus.oBusy      = (state != IDLE) || (count != '0);
    assign ledBus.oOverflow  = rOverflow;
    assign ledBus.oFifoCount = count;

endmodule

// File: tb/tb_led_uart_reporter.sv
// Self-checking bench for led_uart_reporter: directed scenarios plus random LED traffic.
module tb_led_uart_reporter;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic rstN;

    always #5 clk = ~clk;

    led_uart_reporter_if #(.CNT_W(CW)) ledBus ();

    led_uart_reporter #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(DEPTH),
        .CNT_W(CW)
    ) dut (
        .Clock(clk),
        .Reset(rstN),
        .ledBus(ledBus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: queue of pending bytes plus a cycles-left count for the current frame.
    logic [7:0] mQ[$];
    logic [7:0] mSent[$];
    logic [7:0] mPrev;
    logic [7:0] mCur;
    int         mTxLeft;
    bit         mOvf;

    // Bench-side UART receiver decoding oTx.
    bit         rxActive;
    int         rxEl;
    logic [7:0] rxByte;
    logic [7:0] rxQ[$];
    logic [7:0] expQ[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic expTx();
        int el;
        int b;
        if (mTxLeft == 0) return 1'b1;
        el = FRAME - mTxLeft;
        b  = el / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return mCur[b-1];
        return 1'b1;
    endfunction

    task automatic modelEdge();
        logic [7:0] led;
        logic [7:0] head;
        bit         doPop;
        led = ledBus.iLed;
        if (!rstN) begin
            mQ.delete();
            mSent.delete();
            mPrev   = 8'h00;
            mTxLeft = 0;
            mOvf    = 1'b0;
            return;
        end
        doPop = (mTxLeft == 0) && (mQ.size() > 0);
        head  = 8'h00;
        if (doPop) head = mQ.pop_front();
        if (led != mPrev) begin
            if (mQ.size() < DEPTH) mQ.push_back(led);
            else mOvf = 1'b1;
        end
        mPrev = led;
        if (doPop) begin
            mCur    = head;
            mTxLeft = FRAME;
            mSent.push_back(head);
        end else if (mTxLeft > 0) begin
            mTxLeft--;
        end
    endtask

    task automatic rxSample();
        int b;
        if (!rstN) begin
            rxActive = 1'b0;
            return;
        end
        if (!rxActive) begin
            if (ledBus.oTx == 1'b0) begin
                rxActive = 1'b1;
                rxEl     = 0;
            end
        end else begin
            rxEl++;
            b = rxEl / CPB;
            if ((rxEl % CPB) == CPB / 2 && b >= 1 && b <= 8) rxByte[b-1] = ledBus.oTx;
            if (rxEl == FRAME - 1) begin
                rxQ.push_back(rxByte);
                rxActive = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
        chk("tx", 32'(ledBus.oTx), 32'(expTx()));
        chk("fifoCount", 32'(ledBus.oFifoCount), 32'(mQ.size()));
        chk("busy", 32'(ledBus.oBusy), 32'((mTxLeft > 0) || (mQ.size() > 0)));
        chk("overflow", 32'(ledBus.oOverflow), 32'(mOvf));
        rxSample();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chkRx(input string tag);
        chk({tag, "_frames"}, 32'(rxQ.size()), 32'(expQ.size()));
        for (int i = 0; i < expQ.size(); i++) begin
            if (i < rxQ.size()) chk({tag, "_byte"}, 32'(rxQ[i]), 32'(expQ[i]));
        end
        rxQ.delete();
        expQ.delete();
    endtask

    initial begin
        int burstCnt[6];
        int burstLeft;
        int r;
        burstCnt = '{1, 1, 2, 3, 4, 4};

        // Reset and quiet idle
        ledBus.iLed = 8'h00;
        rstN = 1'b0;
        ticks(3);
        chk("rst_tx", 32'(ledBus.oTx), 32'd1);
        chk("rst_cnt", 32'(ledBus.oFifoCount), 32'd0);
        chk("rst_busy", 32'(ledBus.oBusy), 32'd0);
        chk("rst_ovf", 32'(ledBus.oOverflow), 32'd0);
        rstN = 1'b1;
        ticks(500);
        chkRx("idle");

        // Single frame latency
        ledBus.iLed = 8'hA5;
        tick();
        chk("lat_cnt1", 32'(ledBus.oFifoCount), 32'd1);
        tick();
        chk("lat_cnt0", 32'(ledBus.oFifoCount), 32'd0);
        chk("lat_start", 32'(ledBus.oTx), 32'd0);
        ticks(175);
        chk("a5_busy", 32'(ledBus.oBusy), 32'd0);
        expQ.push_back(8'hA5);
        chkRx("a5");

        // Burst overflows the FIFO
        for (int v = 1; v <= 6; v++) begin
            ledBus.iLed = 8'(v);
            tick();
            chk("burst_cnt", 32'(ledBus.oFifoCount), 32'(burstCnt[v-1]));
        end
        chk("burst_ovf", 32'(ledBus.oOverflow), 32'd1);
        ticks(5 * (FRAME + 1) + 20);
        for (int v = 1; v <= 5; v++) expQ.push_back(8'(v));
        chkRx("burst");

        // Same value rewritten every cycle
        for (int i = 0; i < 400; i++) begin
            ledBus.iLed = 8'h3C;
            tick();
        end
        expQ.push_back(8'h3C);
        chkRx("repeat");

        // Reset in the middle of a frame with data queued
        ledBus.iLed = 8'h81;
        tick();
        tick();
        ledBus.iLed = 8'h11;
        tick();
        ledBus.iLed = 8'h22;
        tick();
        ticks(46);
        chk("pre_rst_cnt", 32'(ledBus.oFifoCount), 32'd2);
        rstN = 1'b0;
        ledBus.iLed = 8'h00;
        tick();
        chk("midrst_tx", 32'(ledBus.oTx), 32'd1);
        chk("midrst_cnt", 32'(ledBus.oFifoCount), 32'd0);
        chk("midrst_ovf", 32'(ledBus.oOverflow), 32'd0);
        rxQ.delete();
        rstN = 1'b1;
        ticks(300);
        chkRx("post_rst");

        // Pointer wrap
        for (int i = 0; i < 12; i++) begin
            ledBus.iLed = 8'(8'h10 + i);
            ticks(200);
        end
        ticks(20);
        chk("wrap_ovf", 32'(ledBus.oOverflow), 32'd0);
        for (int i = 0; i < 12; i++) expQ.push_back(8'(8'h10 + i));
        chkRx("wrap");

        // Random LED traffic, including short bursts
        mSent.delete();
        rxQ.delete();
        burstLeft = 0;
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 99));
            if (burstLeft > 0) begin
                ledBus.iLed = 8'($urandom);
                burstLeft--;
            end else if (r < 3) begin
                ledBus.iLed = 8'($urandom);
            end else if (r == 3) begin
                burstLeft = 6;
            end
            tick();
        end
        ticks(5 * (FRAME + 1) + 20);
        foreach (mSent[i]) expQ.push_back(mSent[i]);
        chkRx("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_uart_reporter.md
Name: led_uart_reporter

Overview:
- Downstream consumer of the ALU LED output bus (oLed).
- Detects every change of the 8-bit LED value and queues the new value in a small FIFO.
- Serialises queued values as 8N1 UART frames on one TX pin, so a host can log program progress without probing the LEDs.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit (must be >= 2).
- FIFO_DEPTH, 4, number of queued bytes (power of two, >= 2).
- CNT_W, 3, width of oFifoCount (log2(FIFO_DEPTH)+1).

Ports:
- Clock  input  1  system clock; all logic on its rising edge.
- Reset  input  1  synchronous, active-low reset (Reset==0 at a rising edge resets the block).
- iLed  input  8  LED value from the ALU stage; sampled every cycle.
- oTx  output  1  UART serial output, registered, idle high.
- oBusy  output  1  high when TX FSM is not IDLE or FIFO is non-empty.
- oOverflow  output  1  sticky; set when a change is dropped because the FIFO is full.
- oFifoCount  output  CNT_W  current FIFO occupancy, 0..FIFO_DEPTH.

Behaviour:
Reset (Reset==0 at an edge):
- oTx=1, oBusy=0, oOverflow=0, oFifoCount=0.
- rLedPrev=0, FSM=IDLE, bit/baud counters=0, FIFO pointers=0.
- Applies mid-frame as well: frame aborted, oTx high after that edge, queued data discarded.

Change detection:
- At each edge, if iLed != rLedPrev: push request with data iLed, and rLedPrev<=iLed.
- rLedPrev updates even if the push is dropped.
- After reset, an iLed of 0 causes no push; a nonzero iLed causes a push at the first edge after reset release.

FIFO (circular buffer, read and write pointers plus count):
- Push when count<FIFO_DEPTH, or when count==FIFO_DEPTH and a pop occurs at the same edge.
- Push when full with no pop: data dropped, oOverflow<=1. oOverflow stays 1 until reset.
- Simultaneous push and pop: count unchanged, both accepted.
- No bypass: a pop only uses entries present before the edge. Pop on empty never occurs.
- Pointers wrap modulo FIFO_DEPTH.

TX FSM states: IDLE, START, DATA, STOP.
- IDLE: oTx=1. If count>0 at an edge: pop head into the shift register, clear the baud counter, go to START, oTx<=0.
- START: hold oTx=0 for CLKS_PER_BIT cycles, then go to DATA with oTx<=shift[0], bit index 0.
- DATA: each bit is held CLKS_PER_BIT cycles, LSB first. After bit 7 expires, go to STOP with oTx<=1.
- STOP: hold oTx=1 for CLKS_PER_BIT cycles, then return to IDLE.

Timing:
- A frame is exactly 10*CLKS_PER_BIT cycles of oTx from start-bit fall to stop-bit end.
- Back-to-back frames: one IDLE cycle between stop-bit end and the next start bit. Spacing start-to-start is 10*CLKS_PER_BIT+1 cycles.
- Latency: new iLed first sampled at edge k → push at edge k → pop at edge k+1 (if FSM idle) → oTx low after edge k+1.

Counters:
- Baud counter is 0..CLKS_PER_BIT-1 and wraps at bit boundaries.
- Bit index is 0..7.
- No arithmetic overflow is possible; widths are sized from parameters.

Test Plan:
- Reset low 3 cycles, then iLed=0x00 held for 500 cycles → oTx=1 throughout, oBusy=0, oFifoCount=0, no frame.
- iLed 0x00→0xA5 first sampled at edge k → oFifoCount=1 after k, 0 after k+1. oTx low after k+1 for 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then high 16 cycles; oBusy=0 after frame.
- iLed=0x01..0x06 on six consecutive edges k..k+5 → count 1,1,2,3,4,4. 0x06 is dropped and oOverflow=1. Frames carry 0x01,0x02,0x03,0x04,0x05, each start 161 cycles apart.
- iLed rewritten with the same value 0x3C every cycle for 400 cycles after one 0x3C frame → exactly one frame total.
- Reset asserted at cycle 50 of a 0x81 frame while count=2 → oTx=1, count=0, oOverflow=0 after that edge. After release, no frame until iLed differs from 0x00.
- FIFO wrap: 12 changes spaced 200 cycles apart (0x10..0x1B) → 12 correct frames in order, oOverflow stays 0, pointers wrap 3 times.
